// File: rtl/gray_counter.sv
// gray_counter: Gray-code sequence generator with a valid/ready output handshake.
//
// Counts in binary internally (bin_q) and registers the Gray encoding of the
// next binary value on the same edge, so G never glitches and only one bit
// changes per accepted step, wrap-around included.
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   start      pulse: (re)start from the start value, enter COUNT
//   stop       pulse: leave COUNT for IDLE, holding the current value
//   one_shot   1 = stop at the terminal value, 0 = wrap and keep counting
//   up_dn      1 = count up, 0 = count down
//   load       pulse: replace the count with load_val (state unchanged, DONE -> IDLE)
//   load_val   Gray-coded load value
//   out_ready  consumer accepts G this cycle
//   G          registered Gray word
//   out_valid  G is a live sequence value (state COUNT)
//   wrap       one-cycle pulse after a free-run wrap-around transfer
//   done       level: one-shot sequence finished (state DONE)
module gray_counter #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             stop,
  input  logic             one_shot,
  input  logic             up_dn,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             out_ready,
  output logic [WIDTH-1:0] G,
  output logic             out_valid,
  output logic             wrap,
  output logic             done
);

  typedef enum logic [1:0] {StIdle, StCount, StDone} state_e;

  localparam logic [WIDTH-1:0] One = WIDTH'(1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] bin_q, bin_d;
  logic [WIDTH-1:0] g_q, g_d;
  logic             wrap_q, wrap_d;

  logic [WIDTH-1:0] load_bin;
  logic [WIDTH-1:0] start_val;
  logic [WIDTH-1:0] term_val;
  logic [WIDTH-1:0] step_val;
  logic             xfer;

  // Gray-to-binary: each binary bit is the XOR of all Gray bits at or above it.
  always_comb begin
    logic acc;
    acc      = 1'b0;
    load_bin = '0;
    for (int i = int'(WIDTH) - 1; i >= 0; i--) begin
      acc         = acc ^ load_val[i];
      load_bin[i] = acc;
    end
  end

  assign start_val = up_dn ? '0 : '1;
  assign term_val  = up_dn ? '1 : '0;
  // Natural modulo-2^WIDTH arithmetic: stepping past the terminal value
  // lands exactly on the start value for the same direction.
  assign step_val  = up_dn ? (bin_q + One) : (bin_q - One);
  assign xfer      = (state_q == StCount) && out_ready;

  always_comb begin
    state_d = state_q;
    bin_d   = bin_q;
    wrap_d  = 1'b0;
    if (load) begin
      bin_d = load_bin;
      if (state_q == StDone) begin
        state_d = StIdle;
      end
    end else if (start) begin
      bin_d   = start_val;
      state_d = StCount;
    end else if (stop && (state_q == StCount)) begin
      state_d = StIdle;
    end else if (xfer) begin
      if (bin_q == term_val) begin
        if (one_shot) begin
          state_d = StDone;
        end else begin
          bin_d  = step_val;
          wrap_d = 1'b1;
        end
      end else begin
        bin_d = step_val;
      end
    end
    // G is encoded from the next binary value so it is registered alongside bin_q.
    g_d = bin_d ^ (bin_d >> 1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      bin_q   <= '0;
      g_q     <= '0;
      wrap_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      bin_q   <= bin_d;
      g_q     <= g_d;
      wrap_q  <= wrap_d;
    end
  end

  assign G         = g_q;
  assign wrap      = wrap_q;
  assign out_valid = (state_q == StCount);
  assign done      = (state_q == StDone);

endmodule
